// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath (R0..R15, HI, LO, Y, Z, PC, IR,
// MAR, MDR, InPort, C and a combinational ALU). Every load strobe, bus-drive
// strobe and the ALU opcode come from an external control unit.
// Build option: define DATAPATH_DIV_EN to include the signed divider
// (opcode 01010). Without it that opcode produces Z = 0.
module datapath #(
  parameter int WIDTH = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             Read,
  input  logic             IncPC,
  input  logic [4:0]       opcode,
  input  logic             R0in,  R1in,  R2in,  R3in,
  input  logic             R4in,  R5in,  R6in,  R7in,
  input  logic             R8in,  R9in,  R10in, R11in,
  input  logic             R12in, R13in, R14in, R15in,
  input  logic             HIin,
  input  logic             LOin,
  input  logic             Yin,
  input  logic             Zhighin,
  input  logic             Zlowin,
  input  logic             PCin,
  input  logic             IRin,
  input  logic             MARin,
  input  logic             MDRin,
  input  logic             Inportin,
  input  logic             Cin,
  input  logic             R0out,  R1out,  R2out,  R3out,
  input  logic             R4out,  R5out,  R6out,  R7out,
  input  logic             R8out,  R9out,  R10out, R11out,
  input  logic             R12out, R13out, R14out, R15out,
  input  logic             HIout,
  input  logic             LOout,
  input  logic             Yout,
  input  logic             Zhighout,
  input  logic             Zlowout,
  input  logic             PCout,
  input  logic             IRout,
  input  logic             MARout,
  input  logic             MDRout,
  input  logic             Inportout,
  input  logic             Cout,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic [WIDTH-1:0] InPort_data,
  output logic [WIDTH-1:0] BusMuxOut,
  output logic [WIDTH-1:0] MAR_q
);

  typedef enum logic [4:0] {
    OP_ADD  = 5'b00000,
    OP_SUB  = 5'b00001,
    OP_AND  = 5'b00010,
    OP_OR   = 5'b00011,
    OP_SHR  = 5'b00100,
    OP_SHRA = 5'b00101,
    OP_SHL  = 5'b00110,
    OP_ROR  = 5'b00111,
    OP_ROL  = 5'b01000,
    OP_MUL  = 5'b01001,
    OP_DIV  = 5'b01010,
    OP_NEG  = 5'b01011,
    OP_NOT  = 5'b01100
  } alu_op_e;

  logic [15:0]        r_in;
  logic [15:0]        r_out;
  logic [WIDTH-1:0]   r [16];
  logic [WIDTH-1:0]   hi, lo, y, pc, ir, mar, mdr, inport, c;
  logic [2*WIDTH-1:0] z;
  logic [2*WIDTH-1:0] z_next;

  assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                  R7in,  R6in,  R5in,  R4in,  R3in,  R2in,  R1in, R0in};
  assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                  R7out,  R6out,  R5out,  R4out,  R3out,  R2out,  R1out, R0out};
  assign MAR_q = mar;

  // Bus mux: lowest-priority source first, so higher-priority sources overwrite
  always_comb begin
    // NOTE: the default assignment covers the no-driver case, so no latch is inferred.
    BusMuxOut = '0;
    if (MARout)    BusMuxOut = mar;
    if (IRout)     BusMuxOut = ir;
    if (Yout)      BusMuxOut = y;
    if (Cout)      BusMuxOut = c;
    if (Inportout) BusMuxOut = inport;
    if (MDRout)    BusMuxOut = mdr;
    if (PCout)     BusMuxOut = pc;
    if (Zlowout)   BusMuxOut = z[WIDTH-1:0];
    if (Zhighout)  BusMuxOut = z[2*WIDTH-1:WIDTH];
    if (LOout)     BusMuxOut = lo;
    if (HIout)     BusMuxOut = hi;
    for (int i = 15; i >= 0; i--) begin
      if (r_out[i]) BusMuxOut = r[i];
    end
  end

  // ALU operands: A is always Y, B is always the bus
  alu_op_e            op;
  logic [WIDTH-1:0]   a, b;
  logic [4:0]         sh;
  logic [2*WIDTH-1:0] rot_r, rot_l;
  logic signed [2*WIDTH-1:0] prod;

  function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  function automatic logic [2*WIDTH-1:0] zext(input logic [WIDTH-1:0] v);
    return {{WIDTH{1'b0}}, v};
  endfunction

  assign op    = alu_op_e'(opcode);
  assign a     = y;
  assign b     = BusMuxOut;
  assign sh    = b[4:0];
  assign rot_r = {a, a} >> sh;
  assign rot_l = {a, a} << sh;
  assign prod  = $signed(sext(a)) * $signed(sext(b));

`ifdef DATAPATH_DIV_EN
  // Signed divide via magnitudes: avoids the INT_MIN / -1 overflow and keeps
  // the remainder on the dividend's sign. Divide by zero gives q=all-ones, r=A.
  logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quo   = (b == '0) ? '1 : ((a[WIDTH-1] ^ b[WIDTH-1]) ? -q_mag : q_mag);
  assign rem   = (b == '0) ? a  : (a[WIDTH-1] ? -r_mag : r_mag);
`endif

  // ALU result selection; unsupported opcodes yield zero
  always_comb begin
    z_next = '0;
    case (op)
      OP_ADD:  z_next = sext(a + b);
      OP_SUB:  z_next = sext(a - b);
      OP_AND:  z_next = zext(a & b);
      OP_OR:   z_next = zext(a | b);
      OP_SHR:  z_next = zext(a >> sh);
      OP_SHRA: z_next = zext($signed(a) >>> sh);
      OP_SHL:  z_next = zext(a << sh);
      OP_ROR:  z_next = zext(rot_r[WIDTH-1:0]);
      OP_ROL:  z_next = zext(rot_l[2*WIDTH-1:WIDTH]);
      OP_MUL:  z_next = prod;
`ifdef DATAPATH_DIV_EN
      OP_DIV:  z_next = {rem, quo};
`endif
      OP_NEG:  z_next = sext(-b);
      OP_NOT:  z_next = zext(~b);
      default: z_next = '0;
    endcase
  end

  // General registers R0..R15 load from the bus
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      // NOTE: this array is a bank of flops, not a RAM, so every entry is reset.
      for (int i = 0; i < 16; i++) r[i] <= '0;
    end else begin
      // NOTE: non-blocking so each register samples the bus as it was before the edge.
      for (int i = 0; i < 16; i++) begin
        if (r_in[i]) r[i] <= BusMuxOut;
      end
    end
  end

  // Special registers: HI, LO, Y, IR, MAR, MDR, InPort, C
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      hi     <= '0;
      lo     <= '0;
      y      <= '0;
      ir     <= '0;
      mar    <= '0;
      mdr    <= '0;
      inport <= '0;
      c      <= '0;
    end else begin
      if (HIin)     hi     <= BusMuxOut;
      if (LOin)     lo     <= BusMuxOut;
      if (Yin)      y      <= BusMuxOut;
      if (IRin)     ir     <= BusMuxOut;
      if (MARin)    mar    <= BusMuxOut;
      if (MDRin)    mdr    <= Read ? Mdatain : BusMuxOut;
      if (Inportin) inport <= InPort_data;
      if (Cin)      c      <= {{(WIDTH-19){ir[18]}}, ir[18:0]};
    end
  end

  // Program counter: a bus load overrides the increment
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      pc <= '0;
    end else if (PCin) begin
      pc <= BusMuxOut;
    end else if (IncPC) begin
      pc <= pc + 1'b1;
    end
  end

  // Z result register: each half loads independently from the ALU
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      z <= '0;
    end else begin
      if (Zlowin)  z[WIDTH-1:0]       <= z_next[WIDTH-1:0];
      if (Zhighin) z[2*WIDTH-1:WIDTH] <= z_next[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: self-checking bench for datapath. A table of ALU vectors,
// hand-written multi-cycle sequences (load paths, PC, reset, same-cycle
// load/drive) and randomized ALU / bus-priority traffic against a model.
module tb_datapath;

`ifdef DATAPATH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        clear;
  logic        Read, IncPC;
  logic [4:0]  opcode;
  logic [15:0] rin, rout;
  logic        HIin, LOin, Yin, Zhighin, Zlowin, PCin, IRin, MARin, MDRin, Inportin, Cin;
  logic        HIout, LOout, Yout, Zhighout, Zlowout, PCout, IRout, MARout, MDRout, Inportout, Cout;
  logic [31:0] Mdatain, InPort_data;
  logic [31:0] bus, mar_q;

  int total = 0;
  int bad   = 0;

  // Model of the architectural state, updated by the stimulus tasks
  logic [31:0] m_r [16];
  logic [31:0] m_hi, m_lo, m_y, m_pc, m_mdr, m_inport, m_c, m_ir, m_mar;
  logic [63:0] m_z;

  datapath dut (
    .Clock(Clock), .clear(clear), .Read(Read), .IncPC(IncPC), .opcode(opcode),
    .R0in(rin[0]),   .R1in(rin[1]),   .R2in(rin[2]),   .R3in(rin[3]),
    .R4in(rin[4]),   .R5in(rin[5]),   .R6in(rin[6]),   .R7in(rin[7]),
    .R8in(rin[8]),   .R9in(rin[9]),   .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .HIin(HIin), .LOin(LOin), .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Inportin(Inportin), .Cin(Cin),
    .R0out(rout[0]),   .R1out(rout[1]),   .R2out(rout[2]),   .R3out(rout[3]),
    .R4out(rout[4]),   .R5out(rout[5]),   .R6out(rout[6]),   .R7out(rout[7]),
    .R8out(rout[8]),   .R9out(rout[9]),   .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIout(HIout), .LOout(LOout), .Yout(Yout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .IRout(IRout), .MARout(MARout), .MDRout(MDRout),
    .Inportout(Inportout), .Cout(Cout),
    .Mdatain(Mdatain), .InPort_data(InPort_data),
    .BusMuxOut(bus), .MAR_q(mar_q)
  );

  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL timeout: bench did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    Read = 0; IncPC = 0; opcode = '0; rin = '0; rout = '0;
    HIin = 0; LOin = 0; Yin = 0; Zhighin = 0; Zlowin = 0; PCin = 0;
    IRin = 0; MARin = 0; MDRin = 0; Inportin = 0; Cin = 0;
    HIout = 0; LOout = 0; Yout = 0; Zhighout = 0; Zlowout = 0; PCout = 0;
    IRout = 0; MARout = 0; MDRout = 0; Inportout = 0; Cout = 0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_hi = '0; m_lo = '0; m_y = '0; m_pc = '0; m_mdr = '0;
    m_inport = '0; m_c = '0; m_ir = '0; m_mar = '0; m_z = '0;
  endtask

  // Latch a value into InPort and leave it driving the bus
  task automatic put_bus(input logic [31:0] v);
    idle();
    InPort_data = v; Inportin = 1;
    tick();
    idle();
    m_inport = v;
    Inportout = 1;
  endtask

  task automatic load_r(input int k, input logic [31:0] v);
    put_bus(v); rin[k] = 1; tick(); idle(); m_r[k] = v;
  endtask

  task automatic load_y(input logic [31:0] v);
    put_bus(v); Yin = 1; tick(); idle(); m_y = v;
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [31:0] bv);
    put_bus(bv); opcode = op; Zlowin = 1; Zhighin = 1; tick(); idle();
    m_z = model_alu(op, m_y, bv);
  endtask

  task automatic read_z(output logic [31:0] zl, output logic [31:0] zh);
    idle(); Zlowout = 1;  #1 zl = bus;
    idle(); Zhighout = 1; #1 zh = bus;
    idle();
  endtask

  // ALU reference computed from the arithmetic definition of each operation
  function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r32;
    longint      sa, sb, q, rm, p;
    int          s;
    s  = int'(b % 32);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = longint'(64'd1 << s);
    case (op)
      5'd0: begin r32 = a + b; return 64'(longint'($signed(r32))); end
      5'd1: begin r32 = a - b; return 64'(longint'($signed(r32))); end
      5'd2: return {32'd0, a & b};
      5'd3: return {32'd0, a | b};
      5'd4: begin q = longint'({32'd0, a}) / p; return {32'd0, q[31:0]}; end
      5'd5: begin
        q = sa / p;
        if (sa < 0 && (sa % p) != 0) q = q - 1;
        return {32'd0, q[31:0]};
      end
      5'd6: begin q = longint'({32'd0, a}) * p; return {32'd0, q[31:0]}; end
      5'd7: begin
        r32 = a;
        for (int i = 0; i < s; i++) r32 = {r32[0], r32[31:1]};
        return {32'd0, r32};
      end
      5'd8: begin
        r32 = a;
        for (int i = 0; i < s; i++) r32 = {r32[30:0], r32[31]};
        return {32'd0, r32};
      end
      5'd9: begin q = sa * sb; return 64'(q); end
      5'd10: begin
        if (!DIV_EN) return 64'd0;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb; rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
      5'd11: begin r32 = 32'd0 - b; return 64'(longint'($signed(r32))); end
      5'd12: return {32'd0, ~b};
      default: return 64'd0;
    endcase
  endfunction

  // Bus reference: walk the source list in priority order, first driver wins
  function automatic logic [31:0] model_bus(input logic [15:0] ro, input logic [10:0] so);
    logic [31:0] src [27];
    logic        en  [27];
    logic        found;
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin src[i] = m_r[i]; en[i] = ro[i]; end
    src[16] = m_hi;      en[16] = so[10];
    src[17] = m_lo;      en[17] = so[9];
    src[18] = m_z[63:32]; en[18] = so[8];
    src[19] = m_z[31:0]; en[19] = so[7];
    src[20] = m_pc;      en[20] = so[6];
    src[21] = m_mdr;     en[21] = so[5];
    src[22] = m_inport;  en[22] = so[4];
    src[23] = m_c;       en[23] = so[3];
    src[24] = m_y;       en[24] = so[2];
    src[25] = m_ir;      en[25] = so[1];
    src[26] = m_mar;     en[26] = so[0];
    found = 0; v = '0;
    for (int i = 0; i < 27; i++) begin
      if (en[i] && !found) begin v = src[i]; found = 1; end
    end
    return v;
  endfunction

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] z;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] z);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.z = z;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] zl, zh, exp_bus;
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [63:0] ez;
    logic [15:0] ro;
    logic [10:0] so;

    // ---- ALU vector table: {opcode, A(Y), B(bus), expected Z}
    add_vec(5'b00000, 32'd5,          32'd7,          64'h0000_0000_0000_000C);
    add_vec(5'b00000, 32'hFFFF_FFFF,  32'd1,          64'h0000_0000_0000_0000);
    add_vec(5'b00000, 32'h7FFF_FFFF,  32'd1,          64'hFFFF_FFFF_8000_0000);
    add_vec(5'b00001, 32'd3,          32'd5,          64'hFFFF_FFFF_FFFF_FFFE);
    add_vec(5'b00010, 32'h12,         32'h14,         64'h0000_0000_0000_0010);
    add_vec(5'b00011, 32'hF0,         32'h0F,         64'h0000_0000_0000_00FF);
    add_vec(5'b00100, 32'h8000_0000,  32'd4,          64'h0000_0000_0800_0000);
    add_vec(5'b00101, 32'h8000_0000,  32'd4,          64'h0000_0000_F800_0000);
    add_vec(5'b00110, 32'd1,          32'd31,         64'h0000_0000_8000_0000);
    add_vec(5'b00110, 32'd1,          32'h21,         64'h0000_0000_0000_0002);
    add_vec(5'b00111, 32'd1,          32'd1,          64'h0000_0000_8000_0000);
    add_vec(5'b01000, 32'h8000_0001,  32'd4,          64'h0000_0000_0000_0018);
    add_vec(5'b01001, 32'hFFFF_FFFE,  32'd3,          64'hFFFF_FFFF_FFFF_FFFA);
    add_vec(5'b01001, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000);
    add_vec(5'b01010, 32'd17,         32'd5,          DIV_EN ? 64'h0000_0002_0000_0003 : 64'd0);
    add_vec(5'b01010, 32'd17,         32'd0,          DIV_EN ? 64'h0000_0011_FFFF_FFFF : 64'd0);
    add_vec(5'b01010, 32'hFFFF_FFF9,  32'd2,          DIV_EN ? 64'hFFFF_FFFF_FFFF_FFFD : 64'd0);
    add_vec(5'b01011, 32'd0,          32'd1,          64'hFFFF_FFFF_FFFF_FFFF);
    add_vec(5'b01011, 32'd9,          32'd0,          64'h0000_0000_0000_0000);
    add_vec(5'b01100, 32'd9,          32'd0,          64'h0000_0000_FFFF_FFFF);
    add_vec(5'b11111, 32'd9,          32'd9,          64'h0000_0000_0000_0000);

    idle();
    Mdatain = '0; InPort_data = '0;
    model_reset();

    // ---- Reset state
    clear = 1;
    tick(); tick();
    PCout = 1; #1 check("reset_bus_pc", bus, 32'h0);
    check("reset_mar", mar_q, 32'h0);
    idle();
    clear = 0;
    tick();

    // ---- Load path via MDR from memory, then AND through Y/Z
    Mdatain = 32'h12; Read = 1; MDRin = 1; tick(); idle();
    MDRout = 1; rin[2] = 1; tick(); idle(); m_r[2] = 32'h12;
    Mdatain = 32'h14; Read = 1; MDRin = 1; tick(); idle();
    MDRout = 1; rin[3] = 1; tick(); idle(); m_r[3] = 32'h14;
    rout[2] = 1; #1 check("load_r2", bus, 32'h12); idle();
    rout[3] = 1; #1 check("load_r3", bus, 32'h14); idle();
    rout[2] = 1; Yin = 1; tick(); idle();
    rout[3] = 1; opcode = 5'b00010; Zlowin = 1; tick(); idle();
    Zlowout = 1; rin[1] = 1; tick(); idle();
    rout[1] = 1; #1 check("and_r1", bus, 32'h10); idle();

    // ---- MDR from bus when Read=0
    put_bus(32'hABCD_0123); MDRin = 1; tick(); idle();
    MDRout = 1; #1 check("mdr_from_bus", bus, 32'hABCD_0123); idle();

    // ---- PC: wrap on increment, PCin beats IncPC
    put_bus(32'hFFFF_FFFF); PCin = 1; tick(); idle();
    IncPC = 1; tick(); idle();
    PCout = 1; #1 check("pc_wrap", bus, 32'h0); idle();
    put_bus(32'h40); PCin = 1; IncPC = 1; tick(); idle();
    PCout = 1; #1 check("pc_load_prio", bus, 32'h40); idle();
    IncPC = 1; tick(); idle();
    PCout = 1; #1 check("pc_inc", bus, 32'h41); idle();

    // ---- C sign-extension from IR[18:0]
    put_bus(32'h0004_0000); IRin = 1; tick(); idle();
    Cin = 1; tick(); idle();
    Cout = 1; #1 check("c_neg", bus, 32'hFFFC_0000); idle();
    put_bus(32'hFFF3_FFFF); IRin = 1; tick(); idle();
    Cin = 1; tick(); idle();
    Cout = 1; #1 check("c_pos", bus, 32'h0003_FFFF); idle();

    // ---- Table-driven ALU vectors
    foreach (vecs[i]) begin
      load_y(vecs[i].a);
      alu_op(vecs[i].op, vecs[i].b);
      read_z(zl, zh);
      check($sformatf("vec%0d_zlow", i),  zl, vecs[i].z[31:0]);
      check($sformatf("vec%0d_zhigh", i), zh, vecs[i].z[63:32]);
    end

    // ---- Same-cycle drive and load of Z: bus shows old, Z takes new
    load_y(32'd1);
    alu_op(5'b00000, 32'h100);
    opcode = 5'b00000; Zlowout = 1; Zlowin = 1; Zhighin = 1;
    #1 check("zlow_old_on_bus", bus, 32'h101);
    tick(); idle();
    Zlowout = 1; #1 check("zlow_new_next", bus, 32'h102); idle();
    m_z = 64'h102;

    // ---- Bus priority with randomized register contents and drive strobes
    for (int k = 0; k < 16; k++) load_r(k, $urandom);
    put_bus($urandom); HIin = 1;  tick(); idle(); m_hi  = m_inport;
    put_bus($urandom); LOin = 1;  tick(); idle(); m_lo  = m_inport;
    put_bus($urandom); PCin = 1;  tick(); idle(); m_pc  = m_inport;
    put_bus($urandom); IRin = 1;  tick(); idle(); m_ir  = m_inport;
    Cin = 1; tick(); idle();
    m_c = (m_ir & 32'h0007_FFFF) | ((m_ir & 32'h0004_0000) != 0 ? 32'hFFF8_0000 : 32'h0);
    put_bus($urandom); MARin = 1; tick(); idle(); m_mar = m_inport;
    check("mar_q_load", mar_q, m_mar);
    Mdatain = $urandom; Read = 1; MDRin = 1; tick(); idle(); m_mdr = Mdatain;
    load_y($urandom);
    alu_op(5'b01001, $urandom);
    for (int n = 0; n < 60; n++) begin
      ro = '0; so = '0;
      for (int i = 0; i < 16; i++) ro[i] = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 11; i++) so[i] = ($urandom_range(0, 5) == 0);
      exp_bus = model_bus(ro, so);
      rout = ro;
      {HIout, LOout, Zhighout, Zlowout, PCout, MDRout, Inportout, Cout, Yout, IRout, MARout} = so;
      #1 check($sformatf("prio%0d", n), bus, exp_bus);
      idle();
    end
    idle();
    #1 check("bus_no_driver", bus, 32'h0);

    // ---- Asynchronous clear mid-operation; clear beats simultaneous loads
    tick();
    #1 clear = 1;
    #1 check("clear_async_mar", mar_q, 32'h0);
    rout[5] = 1; #1 check("clear_async_r5", bus, 32'h0); idle();
    Zhighout = 1; #1 check("clear_async_zhigh", bus, 32'h0); idle();
    IncPC = 1; InPort_data = 32'h55; Inportin = 1;
    tick(); tick(); idle();
    clear = 0;
    model_reset();
    PCout = 1; #1 check("clear_pc_after", bus, 32'h0); idle();
    Inportout = 1; #1 check("clear_inport_held", bus, 32'h0); idle();

    // ---- Randomized ALU traffic against the reference model
    for (int n = 0; n < 150; n++) begin
      op = 5'($urandom_range(0, 14));
      if (op > 5'd12) op = 5'($urandom_range(13, 31));
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      load_y(a);
      alu_op(op, b);
      ez = model_alu(op, a, b);
      read_z(zl, zh);
      check($sformatf("rnd%0d_op%0d_zlow", n, op),  zl, ez[31:0]);
      check($sformatf("rnd%0d_op%0d_zhigh", n, op), zh, ez[63:32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
